// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus and register-file write port shared by the
// requesters and the writeback arbiter.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 64,
  parameter int MASK_W  = 8
);
  logic                        WB_EN;
  logic [NUM_REQ-1:0]          REQ_VALID;
  logic [NUM_REQ-1:0]          REQ_READY;
  logic [NUM_REQ*ADDR_W-1:0]   REQ_ADDR;
  logic [NUM_REQ*DATA_W-1:0]   REQ_DATA;
  logic [NUM_REQ*MASK_W-1:0]   REQ_MASK;
  logic                        RegWrite;
  logic [ADDR_W-1:0]           W_ADDR;
  logic [DATA_W-1:0]           W_DATA;
  logic [MASK_W-1:0]           W_MASK;
  logic [31:0]                 PEND_VEC;
  logic [2:0]                  GNT_ID;

  modport master (
    output WB_EN, REQ_VALID, REQ_ADDR, REQ_DATA, REQ_MASK,
    input  REQ_READY, RegWrite, W_ADDR, W_DATA, W_MASK, PEND_VEC, GNT_ID
  );

  modport slave (
    input  WB_EN, REQ_VALID, REQ_ADDR, REQ_DATA, REQ_MASK,
    output REQ_READY, RegWrite, W_ADDR, W_DATA, W_MASK, PEND_VEC, GNT_ID
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between
// NUM_REQ writeback sources, with a one-cycle registered write stage.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 64,
  parameter int MASK_W  = 8
) (
  input logic                CLK,
  input logic                RST,
  regfile_wb_arbiter_if.slave bus
);
  localparam int IDX_W = 3;

  logic [IDX_W-1:0]   ptr_p1;
  logic               found_p0;
  logic [IDX_W-1:0]   gnt_p0;
  logic               vld_p0;
  logic [NUM_REQ-1:0] rdy_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [DATA_W-1:0]  data_p0;
  logic [MASK_W-1:0]  mask_p0;

  logic               vld_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [DATA_W-1:0]  data_p1;
  logic [MASK_W-1:0]  mask_p1;
  logic [IDX_W-1:0]   gnt_p1;

  // Stage p0: search from the pointer upward first, then wrap to the low indices.
  always_comb begin
    found_p0 = 1'b0;
    gnt_p0   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_p0 && bus.REQ_VALID[i] && (IDX_W'(i) >= ptr_p1)) begin
        found_p0 = 1'b1;
        gnt_p0   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_p0 && bus.REQ_VALID[i] && (IDX_W'(i) < ptr_p1)) begin
        found_p0 = 1'b1;
        gnt_p0   = IDX_W'(i);
      end
    end
  end

  assign vld_p0 = found_p0 & bus.WB_EN & ~RST;

  always_comb begin
    rdy_p0  = '0;
    addr_p0 = '0;
    data_p0 = '0;
    mask_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rdy_p0[i] = vld_p0 && (gnt_p0 == IDX_W'(i));
      if (gnt_p0 == IDX_W'(i)) begin
        addr_p0 = bus.REQ_ADDR[ADDR_W*i +: ADDR_W];
        data_p0 = bus.REQ_DATA[DATA_W*i +: DATA_W];
        mask_p0 = bus.REQ_MASK[MASK_W*i +: MASK_W];
      end
    end
  end

  assign bus.REQ_READY = rdy_p0;

  // Stage p1: registered write port; address 0 is accepted but never written.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_p1  <= '0;
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      mask_p1 <= '0;
      gnt_p1  <= '0;
    end else if (vld_p0) begin
      ptr_p1  <= (gnt_p0 == IDX_W'(NUM_REQ-1)) ? '0 : gnt_p0 + 1'b1;
      vld_p1  <= (addr_p0 != '0);
      addr_p1 <= addr_p0;
      data_p1 <= data_p0;
      mask_p1 <= mask_p0;
      gnt_p1  <= gnt_p0;
    end else begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.RegWrite = vld_p1;
  assign bus.W_ADDR   = addr_p1;
  assign bus.W_DATA   = data_p1;
  assign bus.W_MASK   = mask_p1;
  assign bus.GNT_ID   = gnt_p1;
  assign bus.PEND_VEC = vld_p1 ? (32'd1 << addr_p1) : 32'd0;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter with directed
// reset, round-robin, register-0, enable-gating, mask-0 and wrap cases.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic          rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    logic [2:0]    id;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  // reference model state
  int            m_ptr;
  logic [AW-1:0] h_a;
  logic [DW-1:0] h_d;
  logic [MW-1:0] h_m;
  logic [2:0]    h_id;

  // requester-side state
  logic          rv[N];
  logic [AW-1:0] ra[N];
  logic [DW-1:0] rd[N];
  logic [MW-1:0] rm[N];
  logic          wb_en;
  int            dut_g;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; h_a = '0; h_d = '0; h_m = '0; h_id = '0;
  endtask

  task automatic setreq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m);
    rv[i] = 1'b1; ra[i] = a; rd[i] = d; rm[i] = m;
  endtask

  task automatic setrand(input int i);
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 31));
    if ($urandom_range(0, 7) == 0) a = '0;
    setreq(i, a, {$urandom, $urandom}, MW'($urandom));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.REQ_VALID[i]         = rv[i];
      bus.REQ_ADDR[AW*i +: AW] = ra[i];
      bus.REQ_DATA[DW*i +: DW] = rd[i];
      bus.REQ_MASK[MW*i +: MW] = rm[i];
    end
    bus.WB_EN = wb_en;
  endtask

  // Spec rule: first valid requester at or after the pointer, cyclically.
  function automatic int model_grant();
    if (!wb_en) return -1;
    for (int k = 0; k < N; k++) begin
      if (rv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle();
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    drive();
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("ready", 64'(bus.REQ_READY), 64'(exp_rdy));
    dut_g = -1;
    for (int i = 0; i < N; i++) if (bus.REQ_READY[i]) dut_g = i;
    if (g >= 0) begin
      h_a = ra[g]; h_d = rd[g]; h_m = rm[g]; h_id = 3'(g);
      m_ptr = (g + 1) % N;
      sbq.push_back('{rw: (ra[g] != 0), a: h_a, d: h_d, m: h_m, id: h_id});
    end else begin
      sbq.push_back('{rw: 1'b0, a: h_a, d: h_d, m: h_m, id: h_id});
    end
    for (int i = 0; i < N; i++) if (bus.REQ_READY[i]) rv[i] = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, 64'(bus.REQ_READY), 64'd0);
    chk({tag, "_regwrite"}, 64'(bus.RegWrite), 64'd0);
    chk({tag, "_waddr"}, 64'(bus.W_ADDR), 64'd0);
    chk({tag, "_wdata"}, bus.W_DATA, 64'd0);
    chk({tag, "_wmask"}, 64'(bus.W_MASK), 64'd0);
    chk({tag, "_gntid"}, 64'(bus.GNT_ID), 64'd0);
    chk({tag, "_pend"}, 64'(bus.PEND_VEC), 64'd0);
  endtask

  task automatic reset_mid(input string tag);
    @(posedge clk);
    #3;
    for (int i = 0; i < N; i++) if (!rv[i]) setrand(i);
    drive();
    rst = 1'b1;
    #1;
    reset_checks(tag);
    sbq.delete();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20; n++) begin
      if (!(rv[0] || rv[1] || rv[2])) break;
      cycle();
    end
  endtask

  // Monitor: one expected record per cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("regwrite", 64'(bus.RegWrite), 64'(e.rw));
        chk("w_addr", 64'(bus.W_ADDR), 64'(e.a));
        chk("w_data", bus.W_DATA, e.d);
        chk("w_mask", 64'(bus.W_MASK), 64'(e.m));
        chk("gnt_id", 64'(bus.GNT_ID), 64'(e.id));
        chk("pend_vec", 64'(bus.PEND_VEC), e.rw ? (64'd1 << e.a) : 64'd0);
      end else begin
        chk("idle_regwrite", 64'(bus.RegWrite), 64'd0);
      end
    end
  end

  initial begin
    int cnt[N];
    wb_en = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) setrand(i);
    drive();
    #2 rst = 1'b1;
    #1 reset_checks("rst_init");
    @(posedge clk);
    #3 rst = 1'b0;

    // first grant after reset goes to requester 0, then 1, 2
    cycle(); chk("first_grant", 64'(dut_g), 64'(0));
    cycle(); chk("init_grant1", 64'(dut_g), 64'(1));
    cycle(); chk("init_grant2", 64'(dut_g), 64'(2));

    // single requester
    setreq(1, 5'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    cycle(); chk("single_grant", 64'(dut_g), 64'(1));
    cycle();

    // async reset mid-cycle with all valid
    reset_mid("rst_mid");

    // round-robin with all continuously valid
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_order", 64'(dut_g), 64'(k % N));
      if (dut_g >= 0) begin
        cnt[dut_g]++;
        if (k < 5) setrand(dut_g);
      end
    end
    for (int i = 0; i < N; i++) chk("rr_count", 64'(cnt[i]), 64'd2);
    drain();

    // register 0 discard
    setreq(2, 5'd0, 64'h1234_5678_9ABC_DEF0, 8'h0F);
    cycle(); chk("reg0_grant", 64'(dut_g), 64'(2));
    cycle();

    // enable gating; the write accepted just before commits during WB_EN=0
    setreq(1, 5'd9, 64'h0BAD_F00D_0000_0009, 8'h3C);
    cycle(); chk("pre_gate_grant", 64'(dut_g), 64'(1));
    wb_en = 1'b0;
    setreq(0, 5'd12, 64'hA5A5_A5A5_5A5A_5A5A, 8'hF0);
    for (int k = 0; k < 3; k++) begin
      cycle(); chk("gated_grant", 64'(dut_g), -64'sd1);
    end
    wb_en = 1'b1;
    cycle(); chk("ungated_grant", 64'(dut_g), 64'(0));

    // mask 0 still writes
    setreq(1, 5'd7, 64'hFFFF_0000_FFFF_0000, 8'h00);
    cycle(); chk("mask0_grant", 64'(dut_g), 64'(1));

    // wrap/skip from pointer 2 with only req0 and req1 valid
    setrand(0); setrand(1);
    cycle(); chk("wrap_g0", 64'(dut_g), 64'(0));
    setrand(0);
    cycle(); chk("wrap_g1", 64'(dut_g), 64'(1));
    cycle(); chk("wrap_g2", 64'(dut_g), 64'(0));
    drain();

    // random traffic
    for (int k = 0; k < 400; k++) begin
      if (k == 200) reset_mid("rst_rand");
      wb_en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) if (!rv[i] && $urandom_range(0, 1) == 1) setrand(i);
      cycle();
    end
    wb_en = 1'b1;
    drain();
    cycle();

    for (int n = 0; n < 10; n++) begin
      if (sbq.size() == 0) break;
      @(posedge clk);
      #3;
    end
    chk("sb_drain", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
